// File: rtl/ca_frame_writer.sv
// Writer side of the cellular-automaton image memory: builds one frame of a 1-D
// elementary automaton, one generation per row, one cell per clock, raster order.
module ca_frame_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int SEED = COLS / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rule,
  output logic       wr_en,
  output logic [6:0] wr_row,
  output logic [6:0] wr_col,
  output logic       wr_data,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [6:0]      LAST_COL = 7'(COLS - 1);
  localparam logic [6:0]      LAST_ROW = 7'(ROWS - 1);
  localparam logic [COLS-1:0] SEED_VEC = {{(COLS-1){1'b0}}, 1'b1} << SEED;

  logic [1:0]      state_q, state_d;
  logic [COLS-1:0] gen_q, gen_d, gen_next_s;
  logic [7:0]      rule_q, rule_d;
  logic [6:0]      row_q, row_d;
  logic [6:0]      col_q, col_d;
  logic [127:0]    gen_ext_s;

  // Next generation: every cell looks up {left, self, right} in the rule, ring topology.
  always_comb begin
    gen_next_s = '0;
    for (int i = 0; i < COLS; i++) begin
      gen_next_s[i] = rule_q[{gen_q[(i + COLS - 1) % COLS], gen_q[i], gen_q[(i + 1) % COLS]}];
    end
  end

  // Frame sequencing: IDLE -> (WRITE row, STEP)* -> WRITE last row -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    rule_d  = rule_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rule_d  = rule;
          gen_d   = SEED_VEC;
          row_d   = 7'd0;
          col_d   = 7'd0;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (col_q != LAST_COL) begin
          col_d = col_q + 7'd1;
        end else if (row_q != LAST_ROW) begin
          state_d = S_STEP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        gen_d   = gen_next_s;
        row_d   = row_q + 7'd1;
        col_d   = 7'd0;
        state_d = S_WRITE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame simply abandons the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gen_q   <= '0;
      rule_q  <= 8'd0;
      row_q   <= 7'd0;
      col_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      rule_q  <= rule_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Outputs are pure decodes of registers; address/data are held at zero outside WRITE.
  assign gen_ext_s = 128'(gen_q);
  assign wr_en     = (state_q == S_WRITE);
  assign wr_row    = wr_en ? row_q : 7'd0;
  assign wr_col    = wr_en ? col_q : 7'd0;
  assign wr_data   = wr_en & gen_ext_s[col_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
